packet_read_ctrl: RTL and testbench
===================================

# packet_read_ctrl

Read-side pointer controller for the USB-to-Ethernet packet FIFO. It sits opposite the write-side up/down address counter. It drains one committed packet at a time, generating RAM read addresses for the transmitting interface. It holds the packet's bytes until the far end ACKs, rewinds to the packet start on NAK for retransmission, and returns freed space to the writer only after ACK.

## Interface
Parameters:
- ADDR_SIZE, 4, RAM address width; DEPTH = 2^ADDR_SIZE entries; pointers are ADDR_SIZE+1 bits (MSB = wrap bit)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_ptr  in  ADDR_SIZE+1  writer's committed write pointer
- start  in  1  request to send one packet (sampled in IDLE only)
- pkt_len  in  ADDR_SIZE+1  packet length in bytes, valid with start
- pop  in  1  consume one byte at rd_addr (SEND only)
- ack  in  1  packet delivered; release its space (WAIT_HS only)
- nak  in  1  delivery failed; rewind to packet start (SEND or WAIT_HS)
- rd_addr  out  ADDR_SIZE  RAM read address = rd_ptr[ADDR_SIZE-1:0]
- free_ptr  out  ADDR_SIZE+1  base of unacknowledged data; the writer uses it for full detection
- busy  out  1  high in SEND or WAIT_HS
- pkt_done  out  1  one-cycle pulse when the last byte of the packet is popped
- fifo_empty  out  1  high when free_ptr == wr_ptr (nothing held)
- err  out  1  one-cycle pulse on a rejected start or an illegal pop

## Operation
- Registers: rd_ptr, base_ptr (drives free_ptr), len_reg, remaining (ADDR_SIZE+1 bits each), and state.
- Occupancy is occ = (wr_ptr - base_ptr) mod 2^(ADDR_SIZE+1). Unsigned subtraction, wrap bit included; never exceeds DEPTH.
- IDLE
  - If start and 1 <= pkt_len <= occ: len_reg and remaining load pkt_len, rd_ptr = base_ptr, state goes to SEND.
  - If start with pkt_len == 0 or pkt_len > occ: err pulses and state stays IDLE.
  - pop, ack and nak are ignored. pop in IDLE pulses err.
- SEND
  - pop: rd_ptr+1 (wraps naturally mod 2^(ADDR_SIZE+1)) and remaining-1.
  - pop with remaining == 1: pkt_done pulses, state goes to WAIT_HS.
  - nak: rd_ptr = base_ptr, remaining = len_reg, state stays SEND. nak wins over a same-cycle pop.
  - ack in SEND is ignored.
- WAIT_HS
  - ack: base_ptr = rd_ptr, state goes to IDLE.
  - nak: rd_ptr = base_ptr, remaining = len_reg, state goes to SEND.
  - ack and nak together: nak wins, no release.
  - pop pulses err and has no effect.
- start outside IDLE is ignored (no err).
- base_ptr never passes wr_ptr because len is checked against occ at start.

## Timing
- Reset (rst high at a clock edge): rd_ptr = base_ptr = len_reg = remaining = 0, state IDLE.
  - Resulting outputs: rd_addr = 0, free_ptr = 0, busy = 0, pkt_done = 0, err = 0.
  - fifo_empty follows wr_ptr (1 if wr_ptr = 0).
  - rst mid-packet discards the packet with no ACK; the writer must be reset in the same cycle.
- All state, pkt_done and err are registered. Each is visible the cycle after the causing input edge.
- rd_addr is valid the cycle after start is accepted; it advances one cycle after each pop.
- free_ptr updates the cycle after ack.
- busy rises the cycle after start is accepted and falls the cycle after ack.
- fifo_empty is combinational from the free_ptr register and wr_ptr.
- Throughput: one pop per cycle. Minimum packet cycle is start + N pops + ack = N+2 cycles.

## Structure
- A shared package (usb_eth_pkg) holds:
  - the state enum rd_state_t {IDLE, SEND, WAIT_HS};
  - ADDR_SIZE default;
  - a ptr_diff function for wrap-aware occupancy, also used by the writer's full/empty logic.
- One natural sub-module: pkt_len_counter, a loadable down-counter with load/dec/reload and is_one flag holding len_reg and remaining. The rest is a single FSM plus pointer registers.

## Test plan
All scenarios use ADDR_SIZE = 4.
- Reset: rst held 2 cycles with wr_ptr = 0 -> rd_addr = 0, free_ptr = 0, busy = 0, fifo_empty = 1, err = 0.
- Normal send: wr_ptr = 8, start with pkt_len = 4, then 4 pops -> rd_addr 0,1,2,3,4; pkt_done one cycle; busy stays 1. Then ack -> free_ptr = 4, busy = 0, fifo_empty = 0.
- NAK replay: wr_ptr = 8, pkt_len = 4, 3 pops, then nak -> rd_addr = 0. Then 4 pops and ack -> free_ptr = 4. Also nak in WAIT_HS -> back to SEND, rd_addr = 0.
- Wrap-around: base at 14, wr_ptr = 5'b10010, pkt_len = 4 -> rd_addr 14,15,0,1. After ack, free_ptr = 5'b10010 and fifo_empty = 1.
- Rejects: wr_ptr = 3 with pkt_len = 4 -> err pulse, busy = 0. pkt_len = 0 -> err pulse. pop in IDLE -> err pulse, rd_addr unchanged.
- Simultaneous/abort: ack and nak together in WAIT_HS -> free_ptr unchanged, state SEND. rst after 2 pops in SEND -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/usb_eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_eth_pkg
//  Description : Shared types, constants and pointer helpers for the
//                USB-to-Ethernet packet FIFO (reader and writer sides).
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_eth_pkg;

    // Default RAM address width; pointers carry one extra wrap bit.
    localparam int unsigned c_ADDR_SIZE_DEFAULT = 4;

    // Read-side controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HS = 2'd2
    } rd_state_t;

    // Wrap-aware pointer distance (a - b) mod 2^w. Operands are zero-extended
    // to 32 bits by the caller; the result has every bit above w cleared, so
    // it can be compared directly against a zero-extended length.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_len_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_len_counter
//  Description : Loadable down-counter holding the packet length and the
//                number of bytes still to send; reload restores the full
//                length for a retransmission.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_len_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_reload,
    output logic             o_is_one
);

    logic [WIDTH-1:0] r_len;
    logic [WIDTH-1:0] r_remaining;

    // Load takes priority over reload, reload over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_len       <= i_load_val;
            r_remaining <= i_load_val;
        end else if (i_reload) begin
            r_remaining <= r_len;
        end else if (i_dec) begin
            r_remaining <= r_remaining - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_is_one = (r_remaining == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/packet_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : packet_read_ctrl
//  Description : Read-side pointer controller for the packet FIFO. Drains one
//                committed packet at a time, replays it on NAK and releases
//                its space to the writer only after ACK.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_read_ctrl
    import usb_eth_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = c_ADDR_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE:0]   wr_ptr,
    input  logic                 start,
    input  logic [ADDR_SIZE:0]   pkt_len,
    input  logic                 pop,
    input  logic                 ack,
    input  logic                 nak,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [ADDR_SIZE:0]   free_ptr,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 fifo_empty,
    output logic                 err
);

    localparam logic [1:0] c_ST_IDLE    = IDLE;
    localparam logic [1:0] c_ST_SEND    = SEND;
    localparam logic [1:0] c_ST_WAIT_HS = WAIT_HS;

    logic [1:0]         r_state;
    logic [ADDR_SIZE:0] r_rd_ptr;
    logic [ADDR_SIZE:0] r_base_ptr;
    logic               r_pkt_done;
    logic               r_err;

    logic [31:0]        w_occ;
    logic               w_len_ok;
    logic               w_accept;
    logic               w_reload;
    logic               w_dec;
    logic               w_is_one;

    // Occupancy is measured from the oldest unacknowledged byte, so a packet
    // awaiting ACK still counts against what may be started next.
    assign w_occ    = ptr_diff(32'(wr_ptr), 32'(r_base_ptr), ADDR_SIZE + 1);
    assign w_len_ok = (pkt_len != '0) && (w_occ >= 32'(pkt_len));
    assign w_accept = (r_state == c_ST_IDLE) && start && w_len_ok;
    assign w_reload = nak && ((r_state == c_ST_SEND) || (r_state == c_ST_WAIT_HS));
    assign w_dec    = (r_state == c_ST_SEND) && pop && !nak;

    pkt_len_counter #(
        .WIDTH (ADDR_SIZE + 1)
    ) u_len_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (pkt_len),
        .i_dec      (w_dec),
        .i_reload   (w_reload),
        .o_is_one   (w_is_one)
    );

    // Packet FSM with read/base pointers and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_rd_ptr   <= '0;
            r_base_ptr <= '0;
            r_pkt_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_rd_ptr <= r_base_ptr;
                            r_state  <= c_ST_SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    if (pop) begin
                        r_err <= 1'b1;
                    end
                end
                c_ST_SEND: begin
                    // A NAK discards any same-cycle pop and restarts the packet.
                    if (nak) begin
                        r_rd_ptr <= r_base_ptr;
                    end else if (pop) begin
                        r_rd_ptr <= r_rd_ptr + {{ADDR_SIZE{1'b0}}, 1'b1};
                        if (w_is_one) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= c_ST_WAIT_HS;
                        end
                    end
                end
                c_ST_WAIT_HS: begin
                    // NAK beats ACK: the space is kept and the packet replayed.
                    if (nak) begin
                        r_rd_ptr <= r_base_ptr;
                        r_state  <= c_ST_SEND;
                    end else if (ack) begin
                        r_base_ptr <= r_rd_ptr;
                        r_state    <= c_ST_IDLE;
                    end
                    if (pop) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr    = r_rd_ptr[ADDR_SIZE-1:0];
    assign free_ptr   = r_base_ptr;
    assign busy       = (r_state != c_ST_IDLE);
    assign pkt_done   = r_pkt_done;
    assign err        = r_err;
    assign fifo_empty = (r_base_ptr == wr_ptr);

endmodule
`default_nettype wire

// File: tb/tb_packet_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_read_ctrl
//  Description : Directed self-checking bench for packet_read_ctrl
//                (ADDR_SIZE = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_read_ctrl;

    localparam int unsigned c_AW = 4;

    logic            tb_clk;
    logic            rst;
    logic [c_AW:0]   wr_ptr;
    logic            start;
    logic [c_AW:0]   pkt_len;
    logic            pop;
    logic            ack;
    logic            nak;
    logic [c_AW-1:0] rd_addr;
    logic [c_AW:0]   free_ptr;
    logic            busy;
    logic            pkt_done;
    logic            fifo_empty;
    logic            err;

    int total = 0;
    int bad   = 0;

    packet_read_ctrl #(.ADDR_SIZE(c_AW)) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .wr_ptr     (wr_ptr),
        .start      (start),
        .pkt_len    (pkt_len),
        .pop        (pop),
        .ack        (ack),
        .nak        (nak),
        .rd_addr    (rd_addr),
        .free_ptr   (free_ptr),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .fifo_empty (fifo_empty),
        .err        (err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pop = 1'b0; ack = 1'b0; nak = 1'b0;
        pkt_len = '0; wr_ptr = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
        total++; if (free_ptr !== 5'd0) begin bad++; $display("FAIL reset_free_ptr got=%0d want=0", free_ptr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_fifo_empty got=%b want=1", fifo_empty); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_pkt_done got=%b want=0", pkt_done); end
    endtask

    task automatic test_normal_send();
        do_reset();
        wr_ptr = 5'd8; start = 1'b1; pkt_len = 5'd4;
        step(); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL send_busy_rise got=%b want=1", busy); end
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL send_rd_addr0 got=%0d want=0", rd_addr); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; step();
            total++; if (rd_addr !== 4'(i + 1)) begin bad++; $display("FAIL send_rd_addr i=%0d got=%0d want=%0d", i, rd_addr, i + 1); end
            total++; if (pkt_done !== (i == 3)) begin bad++; $display("FAIL send_pkt_done i=%0d got=%b want=%b", i, pkt_done, (i == 3)); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL send_busy i=%0d got=%b want=1", i, busy); end
        end
        pop = 1'b0; step();
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL send_pkt_done_pulse got=%b want=0", pkt_done); end
        total++; if (free_ptr !== 5'd0) begin bad++; $display("FAIL send_free_before_ack got=%0d want=0", free_ptr); end
        ack = 1'b1; step(); ack = 1'b0;
        total++; if (free_ptr !== 5'd4) begin bad++; $display("FAIL send_free_ptr got=%0d want=4", free_ptr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL send_busy_fall got=%b want=0", busy); end
        total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL send_fifo_empty got=%b want=0", fifo_empty); end
    endtask

    task automatic test_nak_replay();
        do_reset();
        wr_ptr = 5'd8; start = 1'b1; pkt_len = 5'd4;
        step(); start = 1'b0;
        pop = 1'b1; step(); step(); step(); pop = 1'b0;
        total++; if (rd_addr !== 4'd3) begin bad++; $display("FAIL nak_pre_rd_addr got=%0d want=3", rd_addr); end
        nak = 1'b1; step(); nak = 1'b0;
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL nak_send_rewind got=%0d want=0", rd_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nak_send_busy got=%b want=1", busy); end
        // The replay must run the full four bytes again.
        pop = 1'b1; step(); step(); step();
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL nak_early_done got=%b want=0", pkt_done); end
        step(); pop = 1'b0;
        total++; if (pkt_done !== 1'b1) begin bad++; $display("FAIL nak_replay_done got=%b want=1", pkt_done); end
        total++; if (rd_addr !== 4'd4) begin bad++; $display("FAIL nak_replay_rd_addr got=%0d want=4", rd_addr); end
        // NAK while waiting for the handshake returns to SEND at the start.
        nak = 1'b1; step(); nak = 1'b0;
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL nak_wait_rewind got=%0d want=0", rd_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nak_wait_busy got=%b want=1", busy); end
        pop = 1'b1; step(); step(); step(); step(); pop = 1'b0;
        total++; if (pkt_done !== 1'b1) begin bad++; $display("FAIL nak_wait_replay_done got=%b want=1", pkt_done); end
        ack = 1'b1; step(); ack = 1'b0;
        total++; if (free_ptr !== 5'd4) begin bad++; $display("FAIL nak_free_ptr got=%0d want=4", free_ptr); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_addr [4];
        exp_addr[0] = 4'd15; exp_addr[1] = 4'd0; exp_addr[2] = 4'd1; exp_addr[3] = 4'd2;
        do_reset();
        // Move the base to 14 with one 14-byte packet.
        wr_ptr = 5'd14; start = 1'b1; pkt_len = 5'd14;
        step(); start = 1'b0;
        pop = 1'b1;
        for (int i = 0; i < 14; i++) step();
        pop = 1'b0; ack = 1'b1; step(); ack = 1'b0;
        total++; if (free_ptr !== 5'd14) begin bad++; $display("FAIL wrap_base got=%0d want=14", free_ptr); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty_mid got=%b want=1", fifo_empty); end
        wr_ptr = 5'b10010; start = 1'b1; pkt_len = 5'd4;
        step(); start = 1'b0;
        total++; if (rd_addr !== 4'd14) begin bad++; $display("FAIL wrap_rd_addr_start got=%0d want=14", rd_addr); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; step();
            total++; if (rd_addr !== exp_addr[i]) begin bad++; $display("FAIL wrap_rd_addr i=%0d got=%0d want=%0d", i, rd_addr, exp_addr[i]); end
        end
        pop = 1'b0;
        total++; if (pkt_done !== 1'b1) begin bad++; $display("FAIL wrap_pkt_done got=%b want=1", pkt_done); end
        ack = 1'b1; step(); ack = 1'b0;
        total++; if (free_ptr !== 5'b10010) begin bad++; $display("FAIL wrap_free_ptr got=%b want=10010", free_ptr); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL wrap_fifo_empty got=%b want=1", fifo_empty); end
    endtask

    task automatic test_rejects();
        do_reset();
        wr_ptr = 5'd3; start = 1'b1; pkt_len = 5'd4;
        step(); start = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_long_err got=%b want=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_long_busy got=%b want=0", busy); end
        step();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rej_err_pulse got=%b want=0", err); end
        start = 1'b1; pkt_len = 5'd0;
        step(); start = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_zero_err got=%b want=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_zero_busy got=%b want=0", busy); end
        pop = 1'b1; step(); pop = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_idle_pop_err got=%b want=1", err); end
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL rej_idle_pop_addr got=%0d want=0", rd_addr); end
        // Length exactly equal to occupancy is accepted.
        start = 1'b1; pkt_len = 5'd3;
        step(); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rej_exact_busy got=%b want=1", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rej_exact_err got=%b want=0", err); end
    endtask

    task automatic test_simul_abort();
        do_reset();
        wr_ptr = 5'd8; start = 1'b1; pkt_len = 5'd2;
        step(); start = 1'b0;
        pop = 1'b1; step(); step(); pop = 1'b0;
        total++; if (pkt_done !== 1'b1) begin bad++; $display("FAIL sim_pkt_done got=%b want=1", pkt_done); end
        pop = 1'b1; step(); pop = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL sim_wait_pop_err got=%b want=1", err); end
        total++; if (rd_addr !== 4'd2) begin bad++; $display("FAIL sim_wait_pop_addr got=%0d want=2", rd_addr); end
        ack = 1'b1; nak = 1'b1; step(); ack = 1'b0; nak = 1'b0;
        total++; if (free_ptr !== 5'd0) begin bad++; $display("FAIL sim_free_ptr got=%0d want=0", free_ptr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sim_busy got=%b want=1", busy); end
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL sim_rd_addr got=%0d want=0", rd_addr); end
        pop = 1'b1; step(); pop = 1'b0;
        total++; if (rd_addr !== 4'd1) begin bad++; $display("FAIL sim_send_pop got=%0d want=1", rd_addr); end
        // Abort a fresh packet after two pops.
        do_reset();
        wr_ptr = 5'd8; start = 1'b1; pkt_len = 5'd4;
        step(); start = 1'b0;
        pop = 1'b1; step(); step(); pop = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL abort_rd_addr got=%0d want=0", rd_addr); end
        total++; if (free_ptr !== 5'd0) begin bad++; $display("FAIL abort_free_ptr got=%0d want=0", free_ptr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (pkt_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL abort_pulses got=%b%b want=00", pkt_done, err); end
        total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL abort_fifo_empty got=%b want=0", fifo_empty); end
    endtask

    initial begin
        test_reset();
        test_normal_send();
        test_nak_replay();
        test_wrap();
        test_rejects();
        test_simul_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
